// File: rtl/qoa_encoder.sv
// QOA sample encoder: 4-tap LMS prediction, residual quantisation against a
// reciprocal scalefactor, and decoder-identical reconstruction/LMS update.
module qoa_encoder (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic [3:0]  sf_index,
  input  logic        hw_wr,
  input  logic        hw_sel,
  input  logic [1:0]  hw_idx,
  input  logic [15:0] hw_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        busy,
  output logic [15:0] recon_out
);

  typedef enum logic [1:0] {IDLE, PREDICT, QUANT, UPDATE} state_t;

  state_t             state, state_nx;
  logic [1:0]         cnt;
  logic signed [15:0] hist [4];
  logic signed [15:0] wts  [4];
  logic signed [15:0] samp;
  logic [3:0]         sf_r;
  logic signed [31:0] acc;
  logic [2:0]         qr_r;

  function automatic logic signed [17:0] recip(input logic [3:0] sf);
    case (sf)
      4'd0:    recip = 18'sd65536;
      4'd1:    recip = 18'sd9363;
      4'd2:    recip = 18'sd3121;
      4'd3:    recip = 18'sd1457;
      4'd4:    recip = 18'sd781;
      4'd5:    recip = 18'sd475;
      4'd6:    recip = 18'sd311;
      4'd7:    recip = 18'sd216;
      4'd8:    recip = 18'sd156;
      4'd9:    recip = 18'sd117;
      4'd10:   recip = 18'sd90;
      4'd11:   recip = 18'sd71;
      4'd12:   recip = 18'sd57;
      4'd13:   recip = 18'sd47;
      4'd14:   recip = 18'sd39;
      default: recip = 18'sd32;
    endcase
  endfunction

  // Index is n+8, so 0..16 covers n = -8..8
  function automatic logic [2:0] quant_tab(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1, 5'd2:   quant_tab = 3'd7;
      5'd3, 5'd4:         quant_tab = 3'd5;
      5'd5, 5'd6:         quant_tab = 3'd3;
      5'd7:               quant_tab = 3'd1;
      5'd8, 5'd9:         quant_tab = 3'd0;
      5'd10, 5'd11:       quant_tab = 3'd2;
      5'd12, 5'd13:       quant_tab = 3'd4;
      default:            quant_tab = 3'd6;
    endcase
  endfunction

  // Shared dequant ROM: per sf, magnitudes for qr[2:1] = 0..3; qr[0] selects sign
  function automatic logic signed [15:0] dequant(input logic [3:0] sf, input logic [2:0] qr);
    logic [63:0] row;
    logic [15:0] mag;
    case (sf)
      4'd0:    row = {16'd7,     16'd5,    16'd3,    16'd1};
      4'd1:    row = {16'd49,    16'd32,   16'd18,   16'd5};
      4'd2:    row = {16'd147,   16'd95,   16'd53,   16'd16};
      4'd3:    row = {16'd315,   16'd203,  16'd113,  16'd34};
      4'd4:    row = {16'd588,   16'd378,  16'd210,  16'd63};
      4'd5:    row = {16'd966,   16'd621,  16'd345,  16'd104};
      4'd6:    row = {16'd1477,  16'd950,  16'd528,  16'd158};
      4'd7:    row = {16'd2128,  16'd1368, 16'd760,  16'd228};
      4'd8:    row = {16'd2947,  16'd1895, 16'd1053, 16'd316};
      4'd9:    row = {16'd3934,  16'd2529, 16'd1405, 16'd422};
      4'd10:   row = {16'd5117,  16'd3290, 16'd1828, 16'd548};
      4'd11:   row = {16'd6496,  16'd4176, 16'd2320, 16'd696};
      4'd12:   row = {16'd8099,  16'd5207, 16'd2893, 16'd868};
      4'd13:   row = {16'd9933,  16'd6386, 16'd3548, 16'd1064};
      4'd14:   row = {16'd12005, 16'd7718, 16'd4288, 16'd1286};
      default: row = {16'd14336, 16'd9216, 16'd5120, 16'd1536};
    endcase
    mag = row[{qr[2:1], 4'b0000} +: 16];
    dequant = qr[0] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [19:0] sgn20(input logic signed [19:0] v);
    if (v > 20'sd0)      sgn20 = 20'sd1;
    else if (v < 20'sd0) sgn20 = -20'sd1;
    else                 sgn20 = 20'sd0;
  endfunction

  logic signed [18:0] pred;
  logic signed [19:0] res_w, n_raw, n_adj, recon_w;
  logic signed [17:0] res;
  logic signed [35:0] prod, n_rnd;
  logic signed [4:0]  n_q;
  logic [4:0]         q_idx;
  logic signed [15:0] dq, delta, recon_c;

  always_comb begin
    pred  = $signed(acc[31:13]);
    res_w = $signed({{4{samp[15]}}, samp}) - $signed({pred[18], pred});
    if (res_w > 20'sd65535)       res = 18'sd65535;
    else if (res_w < -20'sd65535) res = -18'sd65535;
    else                          res = res_w[17:0];
    prod  = res * recip(sf_r);
    n_rnd = (prod + 36'sd32768) >>> 16;
    n_raw = n_rnd[19:0];
    // Nudges a rounded-to-zero result away from zero so any nonzero residual is coded
    n_adj = n_raw + sgn20(res_w) - sgn20(n_raw);
    if (n_adj > 20'sd8)       n_q = 5'sd8;
    else if (n_adj < -20'sd8) n_q = -5'sd8;
    else                      n_q = n_adj[4:0];
    q_idx   = n_q + 5'sd8;
    dq      = dequant(sf_r, qr_r);
    delta   = dq >>> 4;
    recon_w = $signed({pred[18], pred}) + $signed({{4{dq[15]}}, dq});
    if (recon_w > 20'sd32767)       recon_c = 16'sh7fff;
    else if (recon_w < -20'sd32768) recon_c = -16'sh8000;
    else                            recon_c = recon_w[15:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_valid) state_nx = PREDICT;
      PREDICT: if (cnt == 2'd3)  state_nx = QUANT;
      QUANT:   state_nx = UPDATE;
      UPDATE:  if (cnt == 2'd1)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      acc        <= '0;
      samp       <= '0;
      sf_r       <= '0;
      qr_r       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      recon_out  <= '0;
      for (int i = 0; i < 4; i++) begin
        hist[i] <= '0;
        wts[i]  <= '0;
      end
    end else begin
      state      <= state_nx;
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (sample_valid) begin
            samp <= sample_in;
            sf_r <= sf_index;
            acc  <= '0;
          end else if (hw_wr) begin
            if (hw_sel) wts[hw_idx]  <= hw_data;
            else        hist[hw_idx] <= hw_data;
          end
        end
        PREDICT: begin
          acc <= acc + hist[cnt] * wts[cnt];
          cnt <= cnt + 2'd1;
        end
        QUANT: begin
          qr_r <= quant_tab(q_idx);
          cnt  <= 2'd0;
        end
        UPDATE: begin
          cnt <= cnt + 2'd1;
          // Second UPDATE cycle commits so the result lands on the 7th edge
          if (cnt == 2'd1) begin
            byte_out   <= {sf_r, qr_r, 1'b1};
            recon_out  <= recon_c;
            byte_valid <= 1'b1;
            for (int i = 0; i < 4; i++)
              wts[i] <= wts[i] + (hist[i][15] ? -delta : delta);
            hist[0] <= hist[1];
            hist[1] <= hist[2];
            hist[2] <= hist[3];
            hist[3] <= recon_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qoa_encoder.sv
// Randomised + directed bench for qoa_encoder against an arithmetic QOA model.
module tb_qoa_encoder;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [3:0]  sf_index = '0;
  logic        hw_wr = 1'b0;
  logic        hw_sel = 1'b0;
  logic [1:0]  hw_idx = '0;
  logic [15:0] hw_data = '0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        busy;
  logic [15:0] recon_out;

  qoa_encoder dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sample_in(sample_in), .sample_valid(sample_valid), .sf_index(sf_index),
    .hw_wr(hw_wr), .hw_sel(hw_sel), .hw_idx(hw_idx), .hw_data(hw_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .busy(busy), .recon_out(recon_out)
  );

  always #5 sys_clk = ~sys_clk;

  localparam int RECIP [16] = '{65536, 9363, 3121, 1457, 781, 475, 311, 216,
                                156, 117, 90, 71, 57, 47, 39, 32};
  // round((s+1)^2.75)
  localparam int SCALE [16] = '{1, 7, 21, 45, 84, 138, 211, 304,
                                421, 562, 731, 928, 1157, 1419, 1715, 2048};
  localparam int QTAB [17] = '{7, 7, 7, 5, 5, 3, 3, 1, 0, 0, 2, 2, 4, 4, 6, 6, 6};

  int nchk = 0;
  int nerr = 0;
  int nbv  = 0;

  shortint     mh [4];
  shortint     mw [4];
  bit          m_busy = 1'b0;
  bit          exp_bv = 1'b0;
  int          cd = 0;
  logic [7:0]  q_byte = '0, exp_byte = '0;
  logic [15:0] q_recon = '0, exp_recon = '0;

  task automatic chk(string name, longint act, longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(longint v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mh[i] = 0;
      mw[i] = 0;
    end
    m_busy = 1'b0;
    cd = 0;
    exp_byte = '0;
    exp_recon = '0;
  endfunction

  function automatic void encode(int s, int sf);
    int acc, pred, qr, mag, dq, recon, delta;
    longint res, n;
    logic [3:0] sf4;
    logic [2:0] qr3;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += int'(mh[i]) * int'(mw[i]);
    pred = acc >>> 13;
    res = longint'(s) - longint'(pred);
    if (res > 65535) res = 65535;
    if (res < -65535) res = -65535;
    n = (res * RECIP[sf] + 32768) >>> 16;
    n = n + sgn(res) - sgn(n);
    if (n > 8) n = 8;
    if (n < -8) n = -8;
    qr = QTAB[int'(n) + 8];
    // Dequant magnitudes: sf * {0.75, 2.5, 4.5, 7}, rounded half away from zero
    case (qr / 2)
      0:       mag = (3 * SCALE[sf] + 2) / 4;
      1:       mag = (5 * SCALE[sf] + 1) / 2;
      2:       mag = (9 * SCALE[sf] + 1) / 2;
      default: mag = 7 * SCALE[sf];
    endcase
    dq = (qr % 2 == 1) ? -mag : mag;
    recon = pred + dq;
    if (recon > 32767) recon = 32767;
    if (recon < -32768) recon = -32768;
    delta = dq >>> 4;
    for (int i = 0; i < 4; i++)
      mw[i] = shortint'(int'(mw[i]) + ((mh[i] < 0) ? -delta : delta));
    mh[0] = mh[1];
    mh[1] = mh[2];
    mh[2] = mh[3];
    mh[3] = shortint'(recon);
    sf4 = sf[3:0];
    qr3 = qr[2:0];
    q_byte = {sf4, qr3, 1'b1};
    q_recon = recon[15:0];
  endfunction

  // Reference model stepping on every edge, compared 1 time unit later
  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk);
      exp_bv = 1'b0;
      if (!sys_rst_n) model_reset();
      else if (m_busy) begin
        cd--;
        if (cd == 0) begin
          m_busy = 1'b0;
          exp_bv = 1'b1;
          exp_byte = q_byte;
          exp_recon = q_recon;
        end
      end else if (sample_valid) begin
        encode(int'($signed(sample_in)), int'(sf_index));
        m_busy = 1'b1;
        cd = 7;
      end else if (hw_wr) begin
        if (hw_sel) mw[hw_idx] = shortint'(hw_data);
        else        mh[hw_idx] = shortint'(hw_data);
      end
      #1;
      chk("byte_valid", byte_valid, exp_bv);
      chk("busy", busy, m_busy);
      chk("byte_out", byte_out, exp_byte);
      chk("recon_out", $signed(recon_out), $signed(exp_recon));
      if (exp_bv) begin
        nbv++;
        for (int i = 0; i < 4; i++) begin
          chk("lms_hist", $signed(dut.hist[i]), mh[i]);
          chk("lms_wts", $signed(dut.wts[i]), mw[i]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_recon_out", recon_out, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_hist", dut.hist[i], 0);
      chk("rst_wts", dut.wts[i], 0);
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic send(input int s, input int sf);
    @(negedge sys_clk);
    sample_in = 16'(s);
    sf_index = 4'(sf);
    sample_valid = 1'b1;
    @(negedge sys_clk);
    sample_valid = 1'b0;
  endtask

  task automatic hw_write(input bit sel, input int idx, input int data);
    @(negedge sys_clk);
    hw_wr = 1'b1;
    hw_sel = sel;
    hw_idx = 2'(idx);
    hw_data = 16'(data);
    @(negedge sys_clk);
    hw_wr = 1'b0;
  endtask

  // Waits for byte_valid; exp_k = negedges still to go until the 7th edge
  task automatic wait_bv(input string name, input int exp_k);
    int k;
    for (k = 0; k < 20; k++) begin
      if (byte_valid) break;
      @(negedge sys_clk);
    end
    if (k == 20) begin
      nchk++;
      nerr++;
      $display("FAIL %s_timeout: no byte_valid within 20 cycles", name);
    end else chk({name, "_latency"}, k, exp_k);
  endtask

  int bv0;

  initial begin
    do_reset();

    // Zero state, sample 0, sf 0
    send(0, 0);
    wait_bv("z0", 7);
    chk("z0_byte", byte_out, 8'h01);
    chk("z0_recon", $signed(recon_out), 1);
    chk("z0_h3", dut.hist[3], 1);
    chk("z0_h2", dut.hist[2], 0);
    chk("z0_w0", dut.wts[0], 0);

    // Zero state, sample 100, sf 3
    do_reset();
    send(100, 3);
    wait_bv("s100", 7);
    chk("s100_byte", byte_out, 8'h35);
    chk("s100_recon", $signed(recon_out), 113);
    chk("s100_h3", dut.hist[3], 113);
    for (int i = 0; i < 4; i++) chk("s100_w", dut.wts[i], 7);

    // Prediction overshoot: residual and reconstruction both clamp
    do_reset();
    hw_write(1'b1, 3, 16'h4000);
    hw_write(1'b0, 3, 32767);
    send(-32768, 0);
    wait_bv("clamp", 7);
    chk("clamp_byte", byte_out, 8'h0F);
    chk("clamp_recon", $signed(recon_out), 32767);

    // Inputs pulsed while busy are ignored
    do_reset();
    bv0 = nbv;
    send(100, 3);
    @(negedge sys_clk);
    sample_valid = 1'b1;
    sample_in = 16'd5000;
    sf_index = 4'd9;
    hw_wr = 1'b1;
    hw_sel = 1'b1;
    hw_idx = 2'd0;
    hw_data = 16'd1234;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sample_valid = 1'b0;
    hw_wr = 1'b0;
    wait_bv("busy_ign", 4);
    chk("busy_ign_byte", byte_out, 8'h35);
    chk("busy_ign_recon", $signed(recon_out), 113);
    for (int i = 0; i < 4; i++) chk("busy_ign_w", dut.wts[i], 7);
    repeat (10) @(negedge sys_clk);
    chk("busy_ign_count", nbv - bv0, 1);

    // Simultaneous sample and hw_wr in IDLE: write dropped
    do_reset();
    @(negedge sys_clk);
    sample_valid = 1'b1;
    sample_in = 16'd0;
    sf_index = 4'd0;
    hw_wr = 1'b1;
    hw_sel = 1'b0;
    hw_idx = 2'd3;
    hw_data = 16'd500;
    @(negedge sys_clk);
    sample_valid = 1'b0;
    hw_wr = 1'b0;
    wait_bv("simul", 7);
    chk("simul_byte", byte_out, 8'h01);
    chk("simul_h2", dut.hist[2], 0);

    // Reset in PREDICT aborts the sample
    do_reset();
    bv0 = nbv;
    send(100, 3);
    do_reset();
    repeat (10) @(negedge sys_clk);
    chk("abort_count", nbv - bv0, 0);
    send(0, 0);
    wait_bv("after_abort", 7);
    chk("after_abort_byte", byte_out, 8'h01);
    chk("after_abort_recon", $signed(recon_out), 1);

    // Back-to-back: held sample_valid re-accepts the cycle after each pulse
    bv0 = nbv;
    @(negedge sys_clk);
    sample_valid = 1'b1;
    sample_in = 16'(-1200);
    sf_index = 4'd5;
    repeat (24) @(negedge sys_clk);
    sample_valid = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("b2b_count", nbv - bv0, 3);

    // Random traffic, model keeps score every cycle
    for (int it = 0; it < 1500; it++) begin
      @(negedge sys_clk);
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_in = 16'($urandom);
      sf_index = 4'($urandom_range(0, 15));
      hw_wr = ($urandom_range(0, 2) == 0);
      hw_sel = 1'($urandom);
      hw_idx = 2'($urandom);
      hw_data = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 16383)) - 8192);
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
    hw_wr = 1'b0;
    repeat (12) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
